pwm_ramp_ctrl: RTL and testbench

Sequencer for one PWM channel: owns the channel's period, tOn, enable and reset inputs. Accepts target-duty commands over a valid/ready handshake and ramps tOn toward the target in bounded steps. Updates are applied only at period boundaries, so the core never emits a truncated or glitched pulse. Runs on the same 1 us clock as the PWM core and tracks the core counter with a mirror counter.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_step_calc.sv | 22 ++
 rtl/pwm_ramp_ctrl.sv | 154 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM ramp sequencer.
package pwm_pkg;

    localparam int unsigned TON_W           = 8;
    localparam int unsigned PERIOD_W        = 16;
    localparam int unsigned TON_MAX_DEF     = 200;
    localparam int unsigned PERIOD_MIN_DEF  = 2000;
    localparam int unsigned PERIOD_RST_DEF  = 2000;
    localparam int unsigned UPD_PERIODS_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRamp,
        StHold,
        StStop
    } state_e;

endpackage

// File: rtl/pwm_step_calc.sv
// Saturating step of tOn toward a target: moves by min(step, |target - cur|), never overshoots.
module pwm_step_calc
    import pwm_pkg::*;
(
    input  logic [TON_W-1:0] i_cur,
    input  logic [TON_W-1:0] i_target,
    input  logic [TON_W-1:0] i_step,
    output logic [TON_W-1:0] o_next
);

    logic             w_up;
    logic [TON_W-1:0] w_diff;
    logic [TON_W-1:0] w_delta;

    always_comb begin
        w_up    = (i_target >= i_cur);
        w_diff  = w_up ? (i_target - i_cur) : (i_cur - i_target);
        w_delta = (i_step < w_diff) ? i_step : w_diff;
        o_next  = w_up ? (i_cur + w_delta) : (i_cur - w_delta);
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM channel sequencer: accepts duty commands and ramps tOn toward the target,
// applying period/tOn updates only on PWM period boundaries tracked by a mirror counter.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned TON_MAX     = TON_MAX_DEF,
    parameter int unsigned PERIOD_MIN  = PERIOD_MIN_DEF,
    parameter int unsigned PERIOD_RST  = PERIOD_RST_DEF,
    parameter int unsigned UPD_PERIODS = UPD_PERIODS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_stop,
    input  logic [TON_W-1:0]    cmd_target,
    input  logic [TON_W-1:0]    cmd_step,
    input  logic [PERIOD_W-1:0] cmd_period,
    output logic [PERIOD_W-1:0] pwm_period,
    output logic [TON_W-1:0]    pwm_ton,
    output logic                pwm_enable,
    output logic                pwm_reset_n,
    output logic                busy,
    output logic                at_target
);

    localparam int unsigned UPD_W = (UPD_PERIODS > 1) ? $clog2(UPD_PERIODS) : 1;

    localparam logic [TON_W-1:0]    TonMax    = TON_W'(TON_MAX);
    localparam logic [PERIOD_W-1:0] PeriodMin = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] PeriodRst = PERIOD_W'(PERIOD_RST);
    localparam logic [UPD_W-1:0]    UpdLast   = UPD_W'(UPD_PERIODS - 1);

    state_e              r_state;
    state_e              w_state_d;
    logic                r_ready;
    logic                r_reset_n;
    logic                r_enable;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_pend;
    logic [PERIOD_W-1:0] r_mirror;
    logic [TON_W-1:0]    r_ton;
    logic [TON_W-1:0]    r_target;
    logic [TON_W-1:0]    r_step;
    logic [UPD_W-1:0]    r_upd_cnt;

    logic                w_accept;
    logic                w_bnd;
    logic                w_upd;
    logic [TON_W-1:0]    w_next_ton;
    logic [TON_W-1:0]    w_tgt_clip;
    logic [TON_W-1:0]    w_step_clip;
    logic [PERIOD_W-1:0] w_per_clip;

    assign w_accept    = cmd_valid & r_ready;
    assign w_bnd       = r_enable & r_reset_n & (r_mirror == r_period);
    assign w_upd       = w_bnd & (r_upd_cnt == UpdLast);
    assign w_tgt_clip  = (cmd_target > TonMax) ? TonMax : cmd_target;
    assign w_step_clip = (cmd_step == '0) ? TON_W'(1) : cmd_step;
    assign w_per_clip  = (cmd_period < PeriodMin) ? PeriodMin : cmd_period;

    pwm_step_calc u_step_calc (
        .i_cur    (r_ton),
        .i_target (r_target),
        .i_step   (r_step),
        .o_next   (w_next_ton)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept && !cmd_stop) w_state_d = StStart;
            StStart: w_state_d = StRamp;
            StRamp: begin
                if (w_accept) begin
                    w_state_d = cmd_stop ? StStop : StRamp;
                end else if (w_upd && (w_next_ton == r_target)) begin
                    w_state_d = StHold;
                end
            end
            StHold:  if (w_accept) w_state_d = cmd_stop ? StStop : StRamp;
            StStop: begin
                if (w_accept && !cmd_stop) begin
                    w_state_d = StRamp;
                end else if (w_bnd && (r_ton == '0)) begin
                    // tOn=0 still yields a 1-clock pulse, so disable only at the boundary after it
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = !((r_state == StIdle) || (r_state == StHold));
        at_target = (r_state == StHold) && (r_ton == r_target);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready   <= 1'b0;
            r_reset_n <= 1'b0;
            r_enable  <= 1'b0;
            r_period  <= PeriodRst;
            r_pend    <= PeriodRst;
            r_mirror  <= '0;
            r_ton     <= '0;
            r_target  <= '0;
            r_step    <= TON_W'(1);
            r_upd_cnt <= '0;
        end else begin
            r_ready   <= (w_state_d != StStart);
            r_reset_n <= (w_state_d != StStart);
            if (w_accept) begin
                r_target <= cmd_stop ? '0 : w_tgt_clip;
                r_step   <= w_step_clip;
                r_pend   <= w_per_clip;
            end
            if (r_state == StStart) begin
                r_period  <= r_pend;
                r_ton     <= '0;
                r_enable  <= 1'b1;
                r_mirror  <= '0;
                r_upd_cnt <= '0;
            end else if (w_bnd) begin
                r_mirror  <= '0;
                r_period  <= r_pend;
                r_upd_cnt <= w_upd ? '0 : (r_upd_cnt + UPD_W'(1));
                if (w_state_d == StIdle) begin
                    r_enable <= 1'b0;
                end else if (w_upd && ((r_state == StRamp) || (r_state == StStop))) begin
                    r_ton <= w_next_ton;
                end
            end else if (r_enable && r_reset_n) begin
                r_mirror <= r_mirror + PERIOD_W'(1);
            end
        end
    end

    assign cmd_ready   = r_ready;
    assign pwm_period  = r_period;
    assign pwm_ton     = r_ton;
    assign pwm_enable  = r_enable;
    assign pwm_reset_n = r_reset_n;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a queue of expected output snapshots is checked on every
// change of period/tOn/enable, alongside a reference PWM core counter.
module tb_pwm_ramp_ctrl;

    localparam int unsigned TON_MAX     = 200;
    localparam int unsigned PERIOD_MIN  = 20;
    localparam int unsigned PERIOD_RST  = 24;
    localparam int unsigned UPD_PERIODS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_stop = 1'b0;
    logic [7:0]  cmd_target = 8'd0;
    logic [7:0]  cmd_step = 8'd0;
    logic [15:0] cmd_period = 16'd0;
    logic [15:0] pwm_period;
    logic [7:0]  pwm_ton;
    logic        pwm_enable;
    logic        pwm_reset_n;
    logic        busy;
    logic        at_target;

    pwm_ramp_ctrl #(
        .TON_MAX     (TON_MAX),
        .PERIOD_MIN  (PERIOD_MIN),
        .PERIOD_RST  (PERIOD_RST),
        .UPD_PERIODS (UPD_PERIODS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_stop    (cmd_stop),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .cmd_period  (cmd_period),
        .pwm_period  (pwm_period),
        .pwm_ton     (pwm_ton),
        .pwm_enable  (pwm_enable),
        .pwm_reset_n (pwm_reset_n),
        .busy        (busy),
        .at_target   (at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ton;
        logic [15:0] period;
        logic        en;
        int          gap;  // cycles since previous change, 0 = unchecked
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_item;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_chg = 0;
    int mirror_err = 0;
    int glitch_err = 0;

    logic [7:0]  prev_ton = 8'd0;
    logic [15:0] prev_per = 16'(PERIOD_RST);
    logic        prev_en = 1'b0;
    logic [15:0] core_cnt = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int t, input int p, input logic en, input int gap);
        snap_t s;
        s.ton    = 8'(t);
        s.period = 16'(p);
        s.en     = en;
        s.gap    = gap;
        exp_q.push_back(s);
    endtask

    // Reference PWM core counter: 0..period, held while disabled, cleared by core reset.
    always @(posedge clk or negedge pwm_reset_n) begin
        if (!pwm_reset_n) begin
            core_cnt <= 16'd0;
        end else if (pwm_enable) begin
            core_cnt <= (core_cnt == pwm_period) ? 16'd0 : core_cnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (dut.r_mirror !== core_cnt) mirror_err++;
        if (pwm_ton !== prev_ton || pwm_period !== prev_per || pwm_enable !== prev_en) begin
            if (prev_en && pwm_enable && core_cnt != 16'd0) glitch_err++;
            check("sb_change_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_item = exp_q.pop_front();
                check("sb_ton", pwm_ton, mon_item.ton);
                check("sb_period", pwm_period, mon_item.period);
                check("sb_enable", pwm_enable, mon_item.en);
                if (mon_item.gap != 0) check("sb_gap", cyc - last_chg, mon_item.gap);
            end
            last_chg = cyc;
            prev_ton = pwm_ton;
            prev_per = pwm_period;
            prev_en  = pwm_enable;
        end
    end

    task automatic send(input logic stop, input int tgt, input int stp, input int per);
        int n;
        cmd_valid  = 1'b1;
        cmd_stop   = stop;
        cmd_target = 8'(tgt);
        cmd_step   = 8'(stp);
        cmd_period = 16'(per);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_ton(input string tag, input int val, input int limit);
        int n;
        n = 0;
        while (pwm_ton !== 8'(val) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, pwm_ton, 8'(val));
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_period", pwm_period, PERIOD_RST);
        check("rst_ton", pwm_ton, 0);
        check("rst_enable", pwm_enable, 0);
        check("rst_core_reset_n", pwm_reset_n, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_at_target", at_target, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_core_reset_n", pwm_reset_n, 1);
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_enable", pwm_enable, 0);

        // Ramp 0 -> 50 by 10, period 30 (31 clocks), update every 4 periods
        push(0, 30, 1'b1, 0);
        for (int v = 10; v <= 50; v += 10) push(v, 30, 1'b1, 124);
        send(1'b0, 50, 10, 30);
        check("start_core_reset_n", pwm_reset_n, 0);
        check("start_cmd_ready", cmd_ready, 0);
        check("start_busy", busy, 1);
        @(negedge clk);
        check("run_core_reset_n", pwm_reset_n, 1);
        check("run_enable", pwm_enable, 1);
        check("run_cmd_ready", cmd_ready, 1);
        drain("ramp50_done", 1000);
        check("hold50_at_target", at_target, 1);
        check("hold50_busy", busy, 0);

        // Stop from HOLD: 40..0, then disable one period after tOn reaches 0
        push(40, 30, 1'b1, 0);
        for (int v = 30; v >= 0; v -= 10) push(v, 30, 1'b1, 124);
        push(0, 30, 1'b0, 31);
        send(1'b1, 99, 10, 30);
        drain("stop_done", 1200);
        check("idle_busy", busy, 0);
        check("idle_at_target", at_target, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_core_reset_n", pwm_reset_n, 1);

        // Target equal to current tOn: START, then HOLD at first update boundary
        push(0, 30, 1'b1, 0);
        send(1'b0, 0, 3, 30);
        check("eq_start_core_reset_n", pwm_reset_n, 0);
        @(negedge clk);
        check("eq_run_enable", pwm_enable, 1);
        n = 0;
        while (!at_target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("eq_hold_cycles", n, 124);

        // Mid-ramp retarget to 35 with a period change, no overshoot
        push(10, 30, 1'b1, 0);
        push(20, 30, 1'b1, 124);
        push(30, 30, 1'b1, 124);
        send(1'b0, 50, 10, 30);
        wait_ton("reach30", 30, 800);
        push(30, 40, 1'b1, 31);
        push(35, 40, 1'b1, 123);
        send(1'b0, 35, 10, 40);
        drain("retarget_done", 400);
        check("hold35_at_target", at_target, 1);
        check("hold35_ton", pwm_ton, 35);

        // Ramp toward 150 by 5; assert reset once tOn hits 120
        push(40, 40, 1'b1, 0);
        for (int v = 45; v <= 120; v += 5) push(v, 40, 1'b1, 164);
        send(1'b0, 150, 5, 40);
        wait_ton("reach120", 120, 3500);
        check("pre_reset_busy", busy, 1);
        #2;
        push(0, PERIOD_RST, 1'b0, 0);
        reset = 1'b0;
        #1;
        check("async_ton", pwm_ton, 0);
        check("async_period", pwm_period, PERIOD_RST);
        check("async_enable", pwm_enable, 0);
        check("async_core_reset_n", pwm_reset_n, 0);
        check("async_cmd_ready", cmd_ready, 0);
        check("async_busy", busy, 0);
        check("async_at_target", at_target, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel2_cmd_ready", cmd_ready, 1);

        // Clipping: target 250 -> 200, step 0 -> 1, period 5 -> 20
        push(0, PERIOD_MIN, 1'b1, 0);
        for (int v = 1; v <= 200; v++) push(v, PERIOD_MIN, 1'b1, 84);
        send(1'b0, 250, 0, 5);
        check("restart_core_reset_n", pwm_reset_n, 0);
        drain("clip_ramp_done", 17500);
        check("clip_at_target", at_target, 1);
        repeat (100) @(negedge clk);
        check("clip_ton_ceiling", pwm_ton, TON_MAX);

        check("sb_empty", exp_q.size(), 0);
        check("mirror_track", mirror_err, 0);
        check("boundary_only", glitch_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
